// File: rtl/sdio_cia_access_ctrl.sv
// Single-byte CIA register access sequencer: decodes function-0 addresses to CCCR/FBR targets.
// Optional CIS read window enabled by defining SDIO_CIA_CIS_WINDOW_EN.
module sdio_cia_access_ctrl #(
    parameter int NUM_FUNCS = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_req_stb,
    input  logic                       i_req_write,
    input  logic                       i_req_raw,
    input  logic [16:0]                i_req_addr,
    input  logic [7:0]                 i_req_data,
    output logic                       o_busy,
    output logic                       o_req_drop,
    output logic                       o_rsp_stb,
    output logic [7:0]                 o_rsp_data,
    output logic                       o_rsp_err,
    output logic [NUM_FUNCS:0]         o_activate,
    output logic                       o_write_flag,
    output logic [7:0]                 o_address,
    output logic                       o_data_stb,
    output logic [7:0]                 o_wr_data,
    input  logic [8*(NUM_FUNCS+1)-1:0] i_rd_data
`ifdef SDIO_CIA_CIS_WINDOW_EN
    ,
    output logic                       o_cis_activate,
    output logic [16:0]                o_cis_addr,
    input  logic [7:0]                 i_cis_rd_data
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        WR_STB = 3'd2,
        RD_STB = 3'd3,
        RD_CAP = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t          state, next_state;
    logic [16:0]     addr_q;
    logic            write_q;
    logic            raw_q;
    logic [7:0]      data_q;
    logic [7:0]      rsp_data_q;
    logic            rsp_err_q;
    logic [NUM_FUNCS:0] sel;
    logic            cis_hit;
    logic            mapped;
    logic [7:0]      rd_byte;
    logic            cis_act;

    // Target decode works off the latched address, so it is stable for the whole access.
    always_comb begin
        sel    = '0;
        sel[0] = (addr_q[16:8] == 9'd0);
        for (int n = 1; n <= NUM_FUNCS; n++) begin
            sel[n] = (addr_q[16:12] == 5'd0) && (addr_q[11:8] == n[3:0]);
        end
        cis_hit = 1'b0;
`ifdef SDIO_CIA_CIS_WINDOW_EN
        cis_hit = (addr_q[16:12] != 5'd0) && (addr_q[16:12] <= 5'd23);
`endif
        // The CIS window is read-only; a write there is treated like an unmapped address.
        mapped = (|sel) || (cis_hit && !write_q);
    end

    always_comb begin
        rd_byte = 8'h00;
        for (int k = 0; k <= NUM_FUNCS; k++) begin
            if (sel[k]) rd_byte = rd_byte | i_rd_data[8*k +: 8];
        end
`ifdef SDIO_CIA_CIS_WINDOW_EN
        if (cis_hit) rd_byte = i_cis_rd_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state   = state;
        o_busy       = (state != IDLE);
        o_req_drop   = i_req_stb && (state != IDLE);
        o_rsp_stb    = 1'b0;
        o_activate   = '0;
        o_data_stb   = 1'b0;
        o_write_flag = 1'b0;
        cis_act      = 1'b0;
        case (state)
            IDLE: begin
                if (i_req_stb) next_state = DECODE;
            end
            DECODE: begin
                if (!mapped)     next_state = RESP;
                else if (write_q) next_state = WR_STB;
                else             next_state = RD_STB;
            end
            WR_STB: begin
                o_activate   = sel;
                o_data_stb   = 1'b1;
                o_write_flag = 1'b1;
                next_state   = raw_q ? RD_STB : RESP;
            end
            RD_STB: begin
                o_activate = sel;
                o_data_stb = 1'b1;
                cis_act    = cis_hit;
                next_state = RD_CAP;
            end
            RD_CAP: begin
                o_activate = sel;
                cis_act    = cis_hit;
                next_state = RESP;
            end
            RESP: begin
                o_rsp_stb  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Response registers update on entry to RESP and hold until the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            write_q    <= 1'b0;
            raw_q      <= 1'b0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_stb) begin
                        addr_q  <= i_req_addr;
                        write_q <= i_req_write;
                        raw_q   <= i_req_raw && i_req_write;
                        data_q  <= i_req_data;
                    end
                end
                DECODE: begin
                    if (!mapped) begin
                        rsp_data_q <= 8'h00;
                        rsp_err_q  <= 1'b1;
                    end
                end
                WR_STB: begin
                    if (!raw_q) begin
                        rsp_data_q <= data_q;
                        rsp_err_q  <= 1'b0;
                    end
                end
                RD_CAP: begin
                    rsp_data_q <= rd_byte;
                    rsp_err_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_address  = addr_q[7:0];
    assign o_wr_data  = data_q;
    assign o_rsp_data = rsp_data_q;
    assign o_rsp_err  = rsp_err_q;
`ifdef SDIO_CIA_CIS_WINDOW_EN
    assign o_cis_activate = cis_act;
    assign o_cis_addr     = addr_q;
`endif

endmodule

// File: tb/tb_sdio_cia_access_ctrl.sv
// Directed bench for sdio_cia_access_ctrl: CCCR/FBR reads, writes, RAW, unmapped, drops and reset abort.
module tb_sdio_cia_access_ctrl;

    localparam int NF = 7;

    logic              clk;
    logic              rst;
    logic              i_req_stb;
    logic              i_req_write;
    logic              i_req_raw;
    logic [16:0]       i_req_addr;
    logic [7:0]        i_req_data;
    logic              o_busy;
    logic              o_req_drop;
    logic              o_rsp_stb;
    logic [7:0]        o_rsp_data;
    logic              o_rsp_err;
    logic [NF:0]       o_activate;
    logic              o_write_flag;
    logic [7:0]        o_address;
    logic              o_data_stb;
    logic [7:0]        o_wr_data;
    logic [8*(NF+1)-1:0] i_rd_data;
`ifdef SDIO_CIA_CIS_WINDOW_EN
    logic              o_cis_activate;
    logic [16:0]       o_cis_addr;
    logic [7:0]        i_cis_rd_data;
`endif

    int checks;
    int failures;

    // Byte k is what target k returns: CCCR=0x32, FBR1=0x01, FBRn=0xAn otherwise.
    logic [63:0] rd_vec;

    sdio_cia_access_ctrl #(.NUM_FUNCS(NF)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_stb    (i_req_stb),
        .i_req_write  (i_req_write),
        .i_req_raw    (i_req_raw),
        .i_req_addr   (i_req_addr),
        .i_req_data   (i_req_data),
        .o_busy       (o_busy),
        .o_req_drop   (o_req_drop),
        .o_rsp_stb    (o_rsp_stb),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_err    (o_rsp_err),
        .o_activate   (o_activate),
        .o_write_flag (o_write_flag),
        .o_address    (o_address),
        .o_data_stb   (o_data_stb),
        .o_wr_data    (o_wr_data),
        .i_rd_data    (i_rd_data)
`ifdef SDIO_CIA_CIS_WINDOW_EN
        ,
        .o_cis_activate (o_cis_activate),
        .o_cis_addr     (o_cis_addr),
        .i_cis_rd_data  (i_cis_rd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs at the falling edge, then settle so outputs of that cycle can be checked.
    task automatic cyc(input logic r, input logic stb, input logic wr, input logic raw,
                       input logic [16:0] a, input logic [7:0] d, input logic [63:0] rd);
        @(negedge clk);
        rst         = r;
        i_req_stb   = stb;
        i_req_write = wr;
        i_req_raw   = raw;
        i_req_addr  = a;
        i_req_data  = d;
        i_rd_data   = rd;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rd_vec      = {8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'h01, 8'h32};
        rst         = 1'b1;
        i_req_stb   = 1'b0;
        i_req_write = 1'b0;
        i_req_raw   = 1'b0;
        i_req_addr  = '0;
        i_req_data  = '0;
        i_rd_data   = '0;
`ifdef SDIO_CIA_CIS_WINDOW_EN
        i_cis_rd_data = 8'h00;
`endif

        // Reset state
        cyc(1, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        cyc(1, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_rsp_stb", 32'(o_rsp_stb), 32'h0);
        chk("rst_rsp_data", 32'(o_rsp_data), 32'h0);
        chk("rst_rsp_err", 32'(o_rsp_err), 32'h0);
        chk("rst_activate", 32'(o_activate), 32'h0);
        chk("rst_data_stb", 32'(o_data_stb), 32'h0);
        chk("rst_write_flag", 32'(o_write_flag), 32'h0);
        chk("rst_address", 32'(o_address), 32'h0);
        chk("rst_wr_data", 32'(o_wr_data), 32'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("rst_req_drop", 32'(o_req_drop), 32'h0);

        // Read CCCR 0x00000: strobe at cycle 2, response at cycle 4 with 0x32
        cyc(0, 1, 0, 0, 17'h00000, 8'h00, 64'h0);
        chk("rd0_c0_busy", 32'(o_busy), 32'h0);
        chk("rd0_c0_drop", 32'(o_req_drop), 32'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("rd0_c1_busy", 32'(o_busy), 32'h1);
        chk("rd0_c1_stb", 32'(o_data_stb), 32'h0);
        chk("rd0_c1_act", 32'(o_activate), 32'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("rd0_c2_act", 32'(o_activate), 32'h01);
        chk("rd0_c2_stb", 32'(o_data_stb), 32'h1);
        chk("rd0_c2_wf", 32'(o_write_flag), 32'h0);
        chk("rd0_c2_addr", 32'(o_address), 32'h00);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, rd_vec);
        chk("rd0_c3_act", 32'(o_activate), 32'h01);
        chk("rd0_c3_stb", 32'(o_data_stb), 32'h0);
        chk("rd0_c3_rsp", 32'(o_rsp_stb), 32'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("rd0_c4_rsp", 32'(o_rsp_stb), 32'h1);
        chk("rd0_c4_data", 32'(o_rsp_data), 32'h32);
        chk("rd0_c4_err", 32'(o_rsp_err), 32'h0);
        chk("rd0_c4_act", 32'(o_activate), 32'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("rd0_c5_busy", 32'(o_busy), 32'h0);
        chk("rd0_c5_rsp", 32'(o_rsp_stb), 32'h0);
        chk("rd0_c5_hold", 32'(o_rsp_data), 32'h32);

        // Write FBR2 0x00210 data 0x40: strobe at cycle 2, response at cycle 3
        cyc(0, 1, 1, 0, 17'h00210, 8'h40, 64'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("wr_c2_act", 32'(o_activate), 32'h04);
        chk("wr_c2_addr", 32'(o_address), 32'h10);
        chk("wr_c2_wf", 32'(o_write_flag), 32'h1);
        chk("wr_c2_wdata", 32'(o_wr_data), 32'h40);
        chk("wr_c2_stb", 32'(o_data_stb), 32'h1);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("wr_c3_rsp", 32'(o_rsp_stb), 32'h1);
        chk("wr_c3_data", 32'(o_rsp_data), 32'h40);
        chk("wr_c3_err", 32'(o_rsp_err), 32'h0);
        chk("wr_c3_stb", 32'(o_data_stb), 32'h0);
        chk("wr_c3_addr", 32'(o_address), 32'h10);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("wr_c4_busy", 32'(o_busy), 32'h0);

        // RAW to FBR1 0x00111 data 0x05: write strobe c2, read strobe c3, response c5 with 0x01
        cyc(0, 1, 1, 1, 17'h00111, 8'h05, 64'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("raw_c2_act", 32'(o_activate), 32'h02);
        chk("raw_c2_wf", 32'(o_write_flag), 32'h1);
        chk("raw_c2_stb", 32'(o_data_stb), 32'h1);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("raw_c3_stb", 32'(o_data_stb), 32'h1);
        chk("raw_c3_wf", 32'(o_write_flag), 32'h0);
        chk("raw_c3_rsp", 32'(o_rsp_stb), 32'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, rd_vec);
        chk("raw_c4_stb", 32'(o_data_stb), 32'h0);
        chk("raw_c4_rsp", 32'(o_rsp_stb), 32'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("raw_c5_rsp", 32'(o_rsp_stb), 32'h1);
        chk("raw_c5_data", 32'(o_rsp_data), 32'h01);
        chk("raw_c5_wdata", 32'(o_wr_data), 32'h05);

        // Unmapped read 0x00800: no strobe, response at cycle 2 with err
        cyc(0, 1, 0, 0, 17'h00800, 8'h00, 64'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("um_c1_stb", 32'(o_data_stb), 32'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("um_c2_rsp", 32'(o_rsp_stb), 32'h1);
        chk("um_c2_err", 32'(o_rsp_err), 32'h1);
        chk("um_c2_data", 32'(o_rsp_data), 32'h00);
        chk("um_c2_stb", 32'(o_data_stb), 32'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("um_c3_busy", 32'(o_busy), 32'h0);

        // Unmapped write 0x01000 (CIS window, read-only or absent): err, no strobe
        cyc(0, 1, 1, 0, 17'h01000, 8'hC3, 64'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("cisw_c2_rsp", 32'(o_rsp_stb), 32'h1);
        chk("cisw_c2_err", 32'(o_rsp_err), 32'h1);
        chk("cisw_c2_stb", 32'(o_data_stb), 32'h0);

        // Read FBR7 0x00705 with raw=1 but write=0: plain read, byte 7 returned at cycle 4
        cyc(0, 1, 0, 1, 17'h00705, 8'h00, 64'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("rd7_c2_act", 32'(o_activate), 32'h80);
        chk("rd7_c2_wf", 32'(o_write_flag), 32'h0);
        chk("rd7_c2_addr", 32'(o_address), 32'h05);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, rd_vec);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("rd7_c4_rsp", 32'(o_rsp_stb), 32'h1);
        chk("rd7_c4_data", 32'(o_rsp_data), 32'hA7);
        chk("rd7_c4_err", 32'(o_rsp_err), 32'h0);

        // Drops: second request at cycle 2 and during RESP are dropped; request after RESP accepted
        cyc(0, 1, 0, 0, 17'h00000, 8'h00, 64'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        cyc(0, 1, 1, 0, 17'h00300, 8'h99, 64'h0);
        chk("drop_c2", 32'(o_req_drop), 32'h1);
        chk("drop_c2_wf", 32'(o_write_flag), 32'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, rd_vec);
        chk("drop_c3_none", 32'(o_req_drop), 32'h0);
        cyc(0, 1, 1, 0, 17'h00300, 8'h99, 64'h0);
        chk("drop_c4_rsp", 32'(o_rsp_stb), 32'h1);
        chk("drop_c4_data", 32'(o_rsp_data), 32'h32);
        chk("drop_c4_drop", 32'(o_req_drop), 32'h1);
        cyc(0, 1, 1, 0, 17'h00000, 8'h5A, 64'h0);
        chk("acc_c0_busy", 32'(o_busy), 32'h0);
        chk("acc_c0_drop", 32'(o_req_drop), 32'h0);
        chk("acc_c0_rsp", 32'(o_rsp_stb), 32'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("acc_c1_busy", 32'(o_busy), 32'h1);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("acc_c2_act", 32'(o_activate), 32'h01);
        chk("acc_c2_wf", 32'(o_write_flag), 32'h1);
        chk("acc_c2_wdata", 32'(o_wr_data), 32'h5A);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("acc_c3_rsp", 32'(o_rsp_stb), 32'h1);
        chk("acc_c3_data", 32'(o_rsp_data), 32'h5A);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("acc_c4_rsp", 32'(o_rsp_stb), 32'h0);

        // Reset at cycle 2 of a read: aborted, all outputs 0 at cycle 3
        cyc(0, 1, 0, 0, 17'h00142, 8'h00, 64'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        cyc(1, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("ra_c2_act", 32'(o_activate), 32'h02);
        chk("ra_c2_stb", 32'(o_data_stb), 32'h1);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, rd_vec);
        chk("ra_c3_busy", 32'(o_busy), 32'h0);
        chk("ra_c3_rsp", 32'(o_rsp_stb), 32'h0);
        chk("ra_c3_act", 32'(o_activate), 32'h0);
        chk("ra_c3_stb", 32'(o_data_stb), 32'h0);
        chk("ra_c3_data", 32'(o_rsp_data), 32'h0);
        chk("ra_c3_err", 32'(o_rsp_err), 32'h0);
        chk("ra_c3_addr", 32'(o_address), 32'h0);
        chk("ra_c3_wdata", 32'(o_wr_data), 32'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("ra_c4_rsp", 32'(o_rsp_stb), 32'h0);
        cyc(0, 0, 0, 0, 17'h0, 8'h0, 64'h0);
        chk("ra_c5_rsp", 32'(o_rsp_stb), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdio_cia_access_ctrl.md
Name: sdio_cia_access_ctrl

Overview:
Sequencer for single-byte CIA register accesses (CMD52-style) to the CCCR and per-function FBR blocks. Takes one request at a time from the command layer and decodes the 17-bit function-0 address into a one-hot target select plus an 8-bit register offset. Drives each target's activate/strobe/write bus, captures read data, handles read-after-write (RAW) and returns a single-cycle response. Sits between the SDIO command decoder and the CCCR/FBR register blocks.

Parameters:
NUM_FUNCS, 7, number of I/O functions with an FBR (1..7); FBR n is at function-0 address 0x00n00-0x00nFF.

Ports:
clk  in  1  clock
rst  in  1  reset
i_req_stb  in  1  request pulse; sampled only in IDLE
i_req_write  in  1  1=write, 0=read
i_req_raw  in  1  read-after-write; meaningful only with i_req_write=1
i_req_addr  in  17  function-0 register address
i_req_data  in  8  write data
o_busy  out  1  high whenever state != IDLE
o_req_drop  out  1  one-cycle pulse: i_req_stb arrived while busy
o_rsp_stb  out  1  one-cycle response pulse
o_rsp_data  out  8  response data; valid with o_rsp_stb and held until next response
o_rsp_err  out  1  out-of-range address; valid with o_rsp_stb
o_activate  out  NUM_FUNCS+1  one-hot target select: bit0=CCCR, bit n=FBR n
o_write_flag  out  1  target write enable
o_address  out  8  register offset (i_req_addr[7:0])
o_data_stb  out  1  target strobe, one cycle per access
o_wr_data  out  8  write data to target
i_rd_data  in  8*(NUM_FUNCS+1)  packed read data; byte k from target k, valid the cycle after its strobe

Behaviour:
- Reset: rst is synchronous, active-high. All outputs are 0 on reset, including o_rsp_data. State returns to IDLE.
- States: IDLE, DECODE, WR_STB, RD_STB, RD_CAP, RESP.
- IDLE: when i_req_stb=1, latch addr/write/raw/data and go to DECODE.
- DECODE:
  - addr[16:8]==0 selects the CCCR.
  - addr[16:12]==0 and addr[11:8]=n with 1<=n<=NUM_FUNCS selects FBR n.
  - Any other address is unmapped: go to RESP with err=1 and data=0x00. No strobe is issued.
  - A mapped write goes to WR_STB; a mapped read goes to RD_STB.
- WR_STB (1 cycle): o_activate=target, o_data_stb=1, o_write_flag=1, o_wr_data=latched data. Then go to RD_STB if raw=1; otherwise go to RESP with o_rsp_data = written data.
- RD_STB (1 cycle): o_activate=target, o_data_stb=1, o_write_flag=0.
- RD_CAP (1 cycle): o_activate is held; o_data_stb=0. Capture byte k of i_rd_data for the target's index k, then go to RESP.
- RESP (1 cycle): o_rsp_stb=1, o_activate=0, then go to IDLE.
- Latency, counted from the i_req_stb cycle (cycle 0) to the o_rsp_stb cycle:
  - unmapped: 2
  - write: 3
  - read: 4
  - RAW: 5
- o_data_stb is never asserted for more than one consecutive cycle. o_address and o_wr_data stay stable from WR_STB/RD_STB through RESP.
- i_req_stb in any non-IDLE state, including RESP, is ignored and produces o_req_drop=1 in the same cycle. The next request is accepted in IDLE, one cycle after o_rsp_stb.
- i_req_raw with i_req_write=0 is ignored (plain read).
- Reset mid-transaction: abort with no o_rsp_stb; the next cycle is IDLE with all outputs 0.

Optional Feature:
SDIO_CIA_CIS_WINDOW_EN
- Defined: adds ports o_cis_activate (out 1), o_cis_addr (out 17) and i_cis_rd_data (in 8).
  - Addresses 0x01000-0x17FFF are decoded as the CIS window: reads use o_cis_activate, o_cis_addr = full latched address, and the same RD_STB/RD_CAP timing, capturing i_cis_rd_data.
  - Writes to the CIS window are read-only violations: RESP with err=1 and no strobe.
- Not defined: the ports are absent and the CIS window is unmapped (err=1).

Test Plan:
- Read 0x00000, CCCR returns 0x32 -> o_activate=0x01 and o_data_stb at cycle 2; o_rsp_stb at cycle 4 with data=0x32, err=0.
- Write 0x00210 data 0x40 -> cycle 2: o_activate=0x04, o_address=0x10, o_write_flag=1, o_wr_data=0x40; rsp at cycle 3 with data=0x40.
- RAW write 0x00111 data 0x05, FBR1 returns 0x01 -> write strobe at cycle 2, read strobe at cycle 3; rsp at cycle 5 with data=0x01.
- Read 0x00800 (n=8 > NUM_FUNCS) -> no o_data_stb; rsp at cycle 2 with err=1, data=0x00.
- i_req_stb at cycles 0 and 2 -> o_req_drop=1 at cycle 2, only one response; a request issued the cycle after o_rsp_stb is accepted.
- rst at cycle 2 of a read -> no o_rsp_stb; at cycle 3 all outputs are 0 and o_busy=0.
